// File: rtl/hazard_pkg.sv
`default_nettype none
//==============================================================================
// Package  : hazard_pkg
// Brief    : Forward-select encodings and stage record shared by the hazard unit.
// Revision : 1.0 - initial release
//==============================================================================
package hazard_pkg;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    // Register indices are held zero-extended to this width so one record type fits any REG_AW up to it
    localparam int c_MAX_AW = 8;

    typedef struct packed {
        logic                valid;
        logic [c_MAX_AW-1:0] rd;
        logic                regwrite;
        logic                load;
    } stage_rec_t;

    function automatic logic writesReg(input stage_rec_t s);
        return s.valid & s.regwrite & (s.rd != '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
//==============================================================================
// Interface : pipeline_hazard_ctrl_if
// Brief     : Decode/Execute hazard signals and pipeline-register controls.
// Revision  : 1.0 - initial release
//==============================================================================
interface pipeline_hazard_ctrl_if #(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
);

    logic                      id_valid;
    logic [NUM_SRC*REG_AW-1:0] id_rs;
    logic [NUM_SRC-1:0]        id_rs_used;
    logic [REG_AW-1:0]         id_rd;
    logic                      id_regwrite;
    logic                      id_load;
    logic                      ex_branch_taken;
    logic                      stall_f;
    logic                      stall_d;
    logic                      flush_d;
    logic                      flush_e;
    logic [NUM_SRC*2-1:0]      fwd_sel;
    logic [CNT_W-1:0]          stall_cnt;
    logic [CNT_W-1:0]          flush_cnt;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_load, ex_branch_taken,
        input  stall_f, stall_d, flush_d, flush_e, fwd_sel, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_load, ex_branch_taken,
        output stall_f, stall_d, flush_d, flush_e, fwd_sel, stall_cnt, flush_cnt
    );

endinterface
`default_nettype wire

// File: rtl/hazard_fwd_cmp.sv
`default_nettype none
//==============================================================================
// Module   : hazard_fwd_cmp
// Brief    : Forward select for one Execute source operand, MEM before WB.
// Revision : 1.0 - initial release
//==============================================================================
module hazard_fwd_cmp
    import hazard_pkg::*;
(
    input  wire logic [c_MAX_AW-1:0] i_eRs,
    input  wire stage_rec_t          i_mStage,
    input  wire stage_rec_t          i_wStage,
    output logic [1:0]               o_fwdSel
);

    logic w_unused;
    assign w_unused = i_mStage.load ^ i_wStage.load;

    always_comb begin
        o_fwdSel = FWD_NONE;
        if (writesReg(i_mStage) && (i_mStage.rd == i_eRs))
            o_fwdSel = FWD_MEM;
        else if (writesReg(i_wStage) && (i_wStage.rd == i_eRs))
            o_fwdSel = FWD_WB;
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : pipeline_hazard_ctrl
// Brief    : Forwarding, load-use stall and branch flush control for a 5-stage
//            pipeline. Define HAZARD_PERF_EN to build the stall/flush counters.
// Revision : 1.0 - initial release
//==============================================================================
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
) (
    input  wire logic             clk,
    input  wire logic             reset,
    pipeline_hazard_ctrl_if.slave hz
);

    stage_rec_t                       r_eStage;
    stage_rec_t                       r_mStage;
    stage_rec_t                       r_wStage;
    logic [NUM_SRC-1:0][c_MAX_AW-1:0] r_eRs;
    logic [NUM_SRC-1:0]               r_eRsUsed;
    logic [NUM_SRC-1:0][c_MAX_AW-1:0] w_idRs;
    logic [NUM_SRC-1:0][1:0]          w_fwdSel;
    logic                             w_rsHit;
    logic                             w_loadUse;
    logic                             w_branch;
    logic                             w_flushE;
    logic                             w_stallF;
    logic                             w_unused;

    assign w_unused = ^r_eRsUsed;

    always_comb begin
        w_idRs  = '0;
        w_rsHit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_idRs[i] = c_MAX_AW'(hz.id_rs[i*REG_AW +: REG_AW]);
            if (hz.id_rs_used[i] && (w_idRs[i] == r_eStage.rd))
                w_rsHit = 1'b1;
        end
    end

    // Gating with reset drops every control the instant reset falls, even with live inputs
    assign w_loadUse = reset & hz.id_valid & r_eStage.valid & r_eStage.load
                     & (r_eStage.rd != '0) & w_rsHit;
    assign w_branch  = reset & hz.ex_branch_taken;
    assign w_flushE  = w_branch | w_loadUse;
    assign w_stallF  = w_loadUse & ~w_branch;

    assign hz.stall_f = w_stallF;
    assign hz.stall_d = w_stallF;
    assign hz.flush_d = w_branch;
    assign hz.flush_e = w_flushE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_eStage  <= '0;
            r_mStage  <= '0;
            r_wStage  <= '0;
            r_eRs     <= '0;
            r_eRsUsed <= '0;
        end else begin
            r_wStage          <= r_mStage;
            r_mStage          <= r_eStage;
            // Fields load even into a bubble so a released consumer already sees the load in MEM
            r_eStage.valid    <= hz.id_valid & ~w_flushE;
            r_eStage.rd       <= c_MAX_AW'(hz.id_rd);
            r_eStage.regwrite <= hz.id_regwrite;
            r_eStage.load     <= hz.id_load;
            r_eRs             <= w_idRs;
            r_eRsUsed         <= hz.id_rs_used;
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
        hazard_fwd_cmp u_cmp (
            .i_eRs    (r_eRs[g]),
            .i_mStage (r_mStage),
            .i_wStage (r_wStage),
            .o_fwdSel (w_fwdSel[g])
        );
    end

    assign hz.fwd_sel = reset ? w_fwdSel : '0;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] r_stallCnt;
    logic [CNT_W-1:0] r_flushCnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            if (w_stallF && (r_stallCnt != '1))
                r_stallCnt <= r_stallCnt + CNT_W'(1);
            if (w_branch && (r_flushCnt != '1))
                r_flushCnt <= r_flushCnt + CNT_W'(1);
        end
    end

    assign hz.stall_cnt = r_stallCnt;
    assign hz.flush_cnt = r_flushCnt;
`else
    assign hz.stall_cnt = {CNT_W{1'b0}};
    assign hz.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Brief    : Directed table, reset-in-stall sequence and random traffic against
//            an instruction-level reference model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int REG_AW  = 5;
    localparam int NUM_SRC = 2;
    localparam int CNT_W   = 16;
    localparam int CMAX    = (1 << CNT_W) - 1;
`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        bit       valid;
        int       rs0;
        int       rs1;
        bit [1:0] used;
        int       rd;
        bit       rw;
        bit       ld;
    } instr_t;

    typedef struct {
        bit       v;
        int       rs0;
        int       rs1;
        bit [1:0] used;
        int       rd;
        bit       rw;
        bit       ld;
        bit       br;
        int       sf;
        int       sd;
        int       fd;
        int       fe;
        int       fwd;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) bus ();

    pipeline_hazard_ctrl #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (bus)
    );

    // Reference: the last three instructions that entered Execute, youngest first
    instr_t pipe[$];
    int     stallCnt;
    int     flushCnt;
    int     checks = 0;
    int     errors = 0;

    function automatic instr_t nop();
        instr_t n;
        n.valid = 0; n.rs0 = 0; n.rs1 = 0; n.used = 2'b00; n.rd = 0; n.rw = 0; n.ld = 0;
        return n;
    endfunction

    function automatic void modelReset();
        pipe.delete();
        repeat (3) pipe.push_back(nop());
        stallCnt = 0;
        flushCnt = 0;
    endfunction

    function automatic bit produces(instr_t p, int r);
        return p.valid && p.rw && (r != 0) && (p.rd == r);
    endfunction

    // Nearest older producer wins: one stage ahead (MEM) before two ahead (WB)
    function automatic int expFwd(int r);
        if (produces(pipe[1], r)) return 2;
        if (produces(pipe[2], r)) return 1;
        return 0;
    endfunction

    function automatic void modelEval(input instr_t d, input bit br,
                                      output bit sf, output bit sd, output bit fd,
                                      output bit fe, output int fwd);
        bit lu;
        lu  = d.valid && pipe[0].valid && pipe[0].ld && (pipe[0].rd != 0) &&
              ((d.used[0] && d.rs0 == pipe[0].rd) || (d.used[1] && d.rs1 == pipe[0].rd));
        fd  = br;
        fe  = br || lu;
        sf  = lu && !br;
        sd  = sf;
        fwd = expFwd(pipe[0].rs0) + 4 * expFwd(pipe[0].rs1);
    endfunction

    function automatic void modelClock(input instr_t d, input bit fe, input bit sf, input bit br);
        instr_t e;
        e = d;
        e.valid = d.valid && !fe;
        pipe.push_front(e);
        void'(pipe.pop_back());
        if (sf) stallCnt++;
        if (br) flushCnt++;
    endfunction

    function automatic int expCnt(int c);
        if (!PERF) return 0;
        return (c > CMAX) ? CMAX : c;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input instr_t d, input bit br);
        bus.id_valid        = d.valid;
        bus.id_rs           = {REG_AW'(d.rs1), REG_AW'(d.rs0)};
        bus.id_rs_used      = d.used;
        bus.id_rd           = REG_AW'(d.rd);
        bus.id_regwrite     = d.rw;
        bus.id_load         = d.ld;
        bus.ex_branch_taken = br;
    endtask

    // Entered and left at a falling edge; checks half a cycle before the rising edge
    task automatic runCycle(input string tag, input instr_t d, input bit br, input bit useExp,
                            input int xSf, input int xSd, input int xFd, input int xFe,
                            input int xFwd, output bit stalled);
        bit sf, sd, fd, fe;
        int fwd;
        drive(d, br);
        modelEval(d, br, sf, sd, fd, fe, fwd);
        #1;
        check({tag, " stall_f"}, int'(bus.stall_f), useExp ? xSf  : int'(sf));
        check({tag, " stall_d"}, int'(bus.stall_d), useExp ? xSd  : int'(sd));
        check({tag, " flush_d"}, int'(bus.flush_d), useExp ? xFd  : int'(fd));
        check({tag, " flush_e"}, int'(bus.flush_e), useExp ? xFe  : int'(fe));
        check({tag, " fwd_sel"}, int'(bus.fwd_sel), useExp ? xFwd : fwd);
        check({tag, " stall_cnt"}, int'(bus.stall_cnt), expCnt(stallCnt));
        check({tag, " flush_cnt"}, int'(bus.flush_cnt), expCnt(flushCnt));
        @(posedge clk);
        modelClock(d, fe, sf, br);
        @(negedge clk);
        stalled = sf;
    endtask

    function automatic vec_t mk(bit v, int rs0, int rs1, bit [1:0] used, int rd, bit rw, bit ld,
                                bit br, int sf, int sd, int fd, int fe, int fwd);
        vec_t r;
        r.v = v; r.rs0 = rs0; r.rs1 = rs1; r.used = used; r.rd = rd; r.rw = rw; r.ld = ld;
        r.br = br; r.sf = sf; r.sd = sd; r.fd = fd; r.fe = fe; r.fwd = fwd;
        return r;
    endfunction

    function automatic instr_t toInstr(vec_t t);
        instr_t d;
        d.valid = t.v; d.rs0 = t.rs0; d.rs1 = t.rs1; d.used = t.used;
        d.rd = t.rd; d.rw = t.rw; d.ld = t.ld;
        return d;
    endfunction

    function automatic instr_t randInstr();
        instr_t d;
        d.valid = ($urandom_range(0, 9) != 0);
        d.rs0   = $urandom_range(0, 7);
        d.rs1   = $urandom_range(0, 7);
        d.used  = 2'($urandom_range(0, 3));
        d.rd    = $urandom_range(0, 7);
        d.rw    = ($urandom_range(0, 3) != 0);
        d.ld    = ($urandom_range(0, 2) == 0);
        return d;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t   tbl[18];
        instr_t d;
        instr_t lw7;
        instr_t use7;
        bit     stalled;

        // Columns: valid rs0 rs1 used rd rw ld br | stall_f stall_d flush_d flush_e fwd_sel
        tbl[0]  = mk(1, 1,  2, 2'b11,  3, 1, 0, 0,  0, 0, 0, 0, 0);  // add x3,x1,x2
        tbl[1]  = mk(1, 3,  5, 2'b11,  4, 1, 0, 0,  0, 0, 0, 0, 0);  // add x4,x3,x5
        tbl[2]  = mk(0, 0,  0, 2'b00,  0, 0, 0, 0,  0, 0, 0, 0, 2);  // x3 from MEM
        tbl[3]  = mk(1, 1,  2, 2'b11,  3, 1, 0, 0,  0, 0, 0, 0, 0);  // add x3
        tbl[4]  = mk(1, 9, 10, 2'b11,  8, 1, 0, 0,  0, 0, 0, 0, 0);  // unrelated
        tbl[5]  = mk(1, 3, 12, 2'b11, 11, 1, 0, 0,  0, 0, 0, 0, 0);  // uses x3
        tbl[6]  = mk(0, 0,  0, 2'b00,  0, 0, 0, 0,  0, 0, 0, 0, 1);  // x3 from WB
        tbl[7]  = mk(1, 2,  0, 2'b01,  7, 1, 1, 0,  0, 0, 0, 0, 0);  // lw x7
        tbl[8]  = mk(1, 7,  1, 2'b11,  9, 1, 0, 0,  1, 1, 0, 1, 0);  // load-use stall
        tbl[9]  = mk(1, 7,  1, 2'b11,  9, 1, 0, 0,  0, 0, 0, 0, 2);  // release sees MEM
        tbl[10] = mk(0, 0,  0, 2'b00,  0, 0, 0, 0,  0, 0, 0, 0, 1);
        tbl[11] = mk(1, 1,  0, 2'b01,  6, 1, 1, 0,  0, 0, 0, 0, 0);  // lw x6
        tbl[12] = mk(1, 6,  6, 2'b11,  5, 1, 0, 1,  0, 0, 1, 1, 0);  // load-use + branch
        tbl[13] = mk(0, 0,  0, 2'b00,  0, 0, 0, 0,  0, 0, 0, 0, 10);
        tbl[14] = mk(1, 1,  2, 2'b11,  0, 1, 0, 0,  0, 0, 0, 0, 0);  // add x0
        tbl[15] = mk(1, 3,  0, 2'b01,  0, 1, 1, 0,  0, 0, 0, 0, 0);  // lw x0
        tbl[16] = mk(1, 0,  0, 2'b11,  1, 1, 0, 0,  0, 0, 0, 0, 0);  // reads x0, no stall
        tbl[17] = mk(0, 0,  0, 2'b00,  0, 0, 0, 0,  0, 0, 0, 0, 0);  // x0 never forwarded

        reset = 1'b0;
        drive(nop(), 1'b0);
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        check("reset stall_f",   int'(bus.stall_f),   0);
        check("reset stall_d",   int'(bus.stall_d),   0);
        check("reset flush_d",   int'(bus.flush_d),   0);
        check("reset flush_e",   int'(bus.flush_e),   0);
        check("reset fwd_sel",   int'(bus.fwd_sel),   0);
        check("reset stall_cnt", int'(bus.stall_cnt), 0);
        check("reset flush_cnt", int'(bus.flush_cnt), 0);
        @(negedge clk);
        reset = 1'b1;

        for (int k = 0; k < 18; k++) begin
            runCycle($sformatf("row%0d", k), toInstr(tbl[k]), tbl[k].br, 1'b1,
                     tbl[k].sf, tbl[k].sd, tbl[k].fd, tbl[k].fe, tbl[k].fwd, stalled);
        end

        // Reset falling in the middle of a load-use stall
        lw7  = toInstr(tbl[7]);
        use7 = toInstr(tbl[8]);
        runCycle("rst_lw", lw7, 1'b0, 1'b0, 0, 0, 0, 0, 0, stalled);
        drive(use7, 1'b0);
        #1;
        check("pre-reset stall_f", int'(bus.stall_f), 1);
        check("pre-reset flush_e", int'(bus.flush_e), 1);
        reset = 1'b0;
        #1;
        check("in-reset stall_f",   int'(bus.stall_f),   0);
        check("in-reset stall_d",   int'(bus.stall_d),   0);
        check("in-reset flush_e",   int'(bus.flush_e),   0);
        check("in-reset fwd_sel",   int'(bus.fwd_sel),   0);
        check("in-reset stall_cnt", int'(bus.stall_cnt), 0);
        check("in-reset flush_cnt", int'(bus.flush_cnt), 0);
        bus.ex_branch_taken = 1'b1;
        #1;
        check("in-reset branch flush_d", int'(bus.flush_d), 0);
        check("in-reset branch flush_e", int'(bus.flush_e), 0);
        @(posedge clk);
        #1;
        check("in-reset edge stall_f", int'(bus.stall_f), 0);
        @(negedge clk);
        reset = 1'b1;
        modelReset();
        runCycle("post-reset use", use7, 1'b0, 1'b1, 0, 0, 0, 0, 0, stalled);
        runCycle("post-reset nop", nop(), 1'b0, 1'b0, 0, 0, 0, 0, 0, stalled);

        stalled = 1'b0;
        d = nop();
        for (int n = 0; n < 400; n++) begin
            if (!stalled) d = randInstr();
            runCycle($sformatf("rnd%0d", n), d, ($urandom_range(0, 7) == 0), 1'b0,
                     0, 0, 0, 0, 0, stalled);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter NUM_SRC, default 2, source operands per instruction.
REQ-003 SHALL have parameter CNT_W, default 16, performance-counter width.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port id_valid  in  1  Decode holds a valid instruction.
REQ-007 SHALL have port id_rs  in  NUM_SRC*REG_AW  Decode source registers, operand i at bits [i*REG_AW +: REG_AW].
REQ-008 SHALL have port id_rs_used  in  NUM_SRC  operand i actually read.
REQ-009 SHALL have port id_rd  in  REG_AW  Decode destination register.
REQ-010 SHALL have port id_regwrite  in  1  Decode instruction writes rd.
REQ-011 SHALL have port id_load  in  1  Decode instruction result comes from memory (ResultSrc=1).
REQ-012 SHALL have port ex_branch_taken  in  1  Execute redirects PC (PCSrcE).
REQ-013 SHALL have ports stall_f, stall_d, flush_d, flush_e  out  1 each  pipeline-register controls.
REQ-014 SHALL have port fwd_sel  out  NUM_SRC*2  per-operand forward select for the instruction in Execute.
REQ-015 SHALL have ports stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Function
REQ-016 SHALL hold internal stage records E, M, W, each {valid, rd, regwrite, load}; E also holds rs[NUM_SRC] and rs_used.
REQ-017 SHALL, every cycle: W<=M, M<=E; E<=Decode fields if id_valid and not flush_e, else E.valid<=0.
REQ-018 SHALL drive fwd_sel[i] combinationally from registered state: 2'b10 if M.valid, M.regwrite, M.rd!=0, M.rd==E.rs[i]; else 2'b01 if the same holds for W; else 2'b00.
REQ-019 SHALL give MEM priority over WB when both match.
REQ-020 SHALL never forward or stall on register 0.
REQ-021 SHALL detect load-use: id_valid, E.valid, E.load, E.rd!=0 and any i with id_rs_used[i] and id_rs[i]==E.rd.
REQ-022 SHALL, on load-use, assert stall_f=1, stall_d=1, flush_e=1 in the same cycle (one bubble), so the release cycle sees fwd_sel=2'b10.
REQ-023 SHALL, on ex_branch_taken, assert flush_d=1 and flush_e=1 and deassert stall_f and stall_d.
REQ-024 SHALL give branch priority over load-use when both occur in the same cycle.
REQ-025 SHALL make all control outputs combinational: zero latency from inputs and registered state.
REQ-026 SHALL increment stall_cnt per load-use stall cycle and flush_cnt per branch-flush cycle, saturating at all-ones.

Reset
REQ-027 SHALL, on reset low, immediately clear E/M/W valid bits and all fields, counters to 0, fwd_sel=0, stall/flush outputs=0.
REQ-028 SHALL, on reset asserted mid-stall, drop the stall asynchronously; the first post-reset cycle starts with an empty pipeline.

Configuration
REQ-029 SHALL, with macro HAZARD_PERF_EN defined, implement stall_cnt/flush_cnt per REQ-026.
REQ-030 SHALL, without HAZARD_PERF_EN, keep the counter ports present but tie them to 0 with no counter flops.

Structure
REQ-031 SHALL take from package hazard_pkg the fwd_sel localparams (FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10) and typedef stage_rec_t.
REQ-032 SHALL use one sub-module hazard_fwd_cmp (one operand's forward select), instantiated NUM_SRC times in a generate loop.

Verification
REQ-033 SHALL test: add x3 then add x4,x3,x5 back-to-back -> second op in Execute gets fwd_sel[0]=2'b10, no stall.
REQ-034 SHALL test: x3 producer, one unrelated op, then consumer of x3 -> fwd_sel[0]=2'b01.
REQ-035 SHALL test: load x7 followed by use of x7 -> one cycle stall_f=stall_d=flush_e=1, then fwd_sel=2'b10; stall_cnt=1.
REQ-036 SHALL test: load-use and ex_branch_taken in the same cycle -> flush_d=flush_e=1, stall_f=stall_d=0, flush_cnt=1, stall_cnt=0.
REQ-037 SHALL test: writes to x0 followed by reads of x0 -> fwd_sel=2'b00 and no stall.
REQ-038 SHALL test: reset pulled low during a stall cycle -> all outputs 0 immediately; with HAZARD_PERF_EN undefined, counters stay 0 throughout.
